// File: rtl/uart_8250_wb_init.sv
// uart_8250_wb_init: Wishbone initiator that programs a uart_8250 and bridges byte streams to THR/RBR.
// Optional WB_ACK_TIMEOUT_EN: abort bus cycles that see no ACK within ACK_TIMEOUT cycles and flag bus_err.
module uart_8250_wb_init #(
  parameter logic [31:0] BASE_ADDR   = 32'h1250_0000,
  parameter int          REG_STRIDE  = 4,
  parameter logic [15:0] DIVISOR     = 16'd27,
  parameter logic [7:0]  LCR_VAL     = 8'h03,
  parameter logic [7:0]  FCR_VAL     = 8'h07,
  parameter int          ACK_TIMEOUT = 255
) (
  input  logic        CLK_I,
  input  logic        RST_I,
  output logic [31:0] ADR_O,
  output logic [31:0] DAT_O,
  input  logic [31:0] DAT_I,
  output logic        WE_O,
  output logic [3:0]  SEL_O,
  output logic        STB_O,
  input  logic        ACK_I,
  output logic        CYC_O,
  input  logic        INT_I,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  output logic        init_done,
  output logic        bus_err
);
  typedef enum logic [3:0] {
    S_W_LCR_DLAB, S_W_DLL, S_W_DLM, S_W_LCR, S_W_FCR, S_W_IER,
    S_IDLE, S_RD_LSR, S_RD_RBR, S_WR_THR
  } state_t;
  state_t      r_state, w_next;
  logic        r_cyc, r_we, r_rx_valid, r_init_done;
  logic [31:0] r_adr, r_dat;
  logic [3:0]  r_sel;
  logic [7:0]  r_rx_data;
  logic [2:0]  w_off;
  logic [7:0]  w_wbyte, w_rbyte;
  logic        w_we, w_ack, w_tmo, w_unused;
  logic [31:0] w_adr;
  logic [3:0]  w_sel;
  assign w_ack    = r_cyc & ACK_I;
  assign w_adr    = BASE_ADDR + 32'(w_off) * 32'(REG_STRIDE);
  assign w_sel    = (REG_STRIDE == 4) ? 4'b0001 : 4'b0001 << w_adr[1:0];
  assign w_rbyte  = (REG_STRIDE == 4) ? DAT_I[7:0] : DAT_I[{r_adr[1:0], 3'b000} +: 8];
  assign w_unused = &{1'b0, INT_I, DAT_I};
  assign ADR_O     = r_adr;
  assign DAT_O     = r_dat;
  assign WE_O      = r_we;
  assign SEL_O     = r_sel;
  assign STB_O     = r_cyc;
  assign CYC_O     = r_cyc;
  assign tx_ready  = w_ack && r_state == S_WR_THR;
  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign init_done = r_init_done;
`ifdef WB_ACK_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;
  logic        r_bus_err;
  assign w_tmo   = r_cyc && !ACK_I && r_tmo_cnt == 16'(ACK_TIMEOUT - 1);
  assign bus_err = r_bus_err;
  // count cycles spent waiting for ACK in the current bus cycle
  always_ff @(posedge CLK_I)
    if (RST_I || !r_cyc) r_tmo_cnt <= '0;
    else r_tmo_cnt <= r_tmo_cnt + 16'd1;
  // sticky record of any aborted bus cycle
  always_ff @(posedge CLK_I)
    if (RST_I) r_bus_err <= 1'b0;
    else if (w_tmo) r_bus_err <= 1'b1;
`else
  assign w_tmo   = 1'b0;
  assign bus_err = 1'b0;
`endif
  // register offset, write byte and direction of the access each state performs
  always_comb begin
    w_off   = 3'd0;
    w_wbyte = 8'h00;
    w_we    = 1'b1;
    case (r_state)
      S_W_LCR_DLAB: begin w_off = 3'd3; w_wbyte = 8'h80; end
      S_W_DLL:      w_wbyte = DIVISOR[7:0];
      S_W_DLM:      begin w_off = 3'd1; w_wbyte = DIVISOR[15:8]; end
      S_W_LCR:      begin w_off = 3'd3; w_wbyte = LCR_VAL & 8'h7F; end
      S_W_FCR:      begin w_off = 3'd2; w_wbyte = FCR_VAL; end
      S_W_IER:      w_off = 3'd1;
      S_RD_LSR:     begin w_off = 3'd5; w_we = 1'b0; end
      S_RD_RBR:     w_we = 1'b0;
      S_WR_THR:     w_wbyte = tx_data;
      default:      w_we = 1'b0;
    endcase
  end
  // advance on ACK; RX wins over TX after an LSR poll; aborted runtime accesses fall back to IDLE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   w_next = S_RD_LSR;
      S_RD_LSR: if (w_ack) w_next = (w_rbyte[0] && !r_rx_valid) ? S_RD_RBR :
                                    (w_rbyte[5] && tx_valid) ? S_WR_THR : S_IDLE;
      S_RD_RBR, S_WR_THR, S_W_IER: if (w_ack) w_next = S_IDLE;
      default:  if (w_ack) w_next = state_t'(r_state + 4'd1);
    endcase
    if (w_tmo && r_state inside {S_RD_LSR, S_RD_RBR, S_WR_THR}) w_next = S_IDLE;
  end
  // state register
  always_ff @(posedge CLK_I)
    if (RST_I) r_state <= S_W_LCR_DLAB;
    else r_state <= w_next;
  // bus cycle launch/termination, RX holding register and init flag
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      r_cyc       <= 1'b0;
      r_we        <= 1'b0;
      r_adr       <= '0;
      r_dat       <= '0;
      r_sel       <= '0;
      r_rx_valid  <= 1'b0;
      r_rx_data   <= '0;
      r_init_done <= 1'b0;
    end else begin
      if (w_ack || w_tmo) r_cyc <= 1'b0;
      else if (!r_cyc && r_state != S_IDLE) begin
        r_cyc <= 1'b1;
        r_adr <= w_adr;
        r_dat <= {4{w_wbyte}};
        r_we  <= w_we;
        r_sel <= w_sel;
      end
      if (w_ack && r_state == S_RD_RBR) begin
        r_rx_data  <= w_rbyte;
        r_rx_valid <= 1'b1;
      end else if (r_rx_valid && rx_ready) r_rx_valid <= 1'b0;
      if (w_ack && r_state == S_W_IER) r_init_done <= 1'b1;
    end
  end
endmodule

// File: doc/uart_8250_wb_init.md
Name: uart_8250_wb_init

Overview:
Wishbone classic initiator that drives the uart_8250 responder on the Wishbone interface the UART exposes.
- After reset it programs the UART: baud divisor, line control and FIFO control.
- It then polls LSR continuously and moves bytes between byte streams and THR/RBR.
- It sits between a simple byte-stream client (boot console, debug monitor) and the UART's Wishbone port.

Parameters:
BASE_ADDR, 32'h1250_0000, UART register base (byte address)
REG_STRIDE, 4, byte distance between UART registers; legal values 1 or 4
DIVISOR, 16'd27, value written to DLL/DLM
LCR_VAL, 8'h03, final LCR value (8N1, DLAB=0)
FCR_VAL, 8'h07, FCR value (FIFO enable, clear RX and TX FIFOs)
ACK_TIMEOUT, 255, cycles to wait for ACK_I (used only when the optional feature is enabled)

Ports:
CLK_I  in  1  clock
RST_I  in  1  synchronous active-high reset
ADR_O  out  32  Wishbone address
DAT_O  out  32  Wishbone write data
DAT_I  in  32  Wishbone read data
WE_O  out  1  write enable
SEL_O  out  4  byte select
STB_O  out  1  strobe
ACK_I  in  1  acknowledge
CYC_O  out  1  cycle
INT_I  in  1  UART interrupt; unused (IER is programmed to 0), accepted for port compatibility
tx_data  in  8  byte to transmit
tx_valid  in  1  tx_data valid; tx_data must be held stable while tx_valid is high
tx_ready  out  1  byte accepted this cycle
rx_data  out  8  received byte
rx_valid  out  1  rx_data valid
rx_ready  in  1  consumer accepts rx_data
init_done  out  1  initialisation complete
bus_err  out  1  sticky ACK timeout flag; constant 0 without the optional feature

Behaviour:
- Register offsets, each multiplied by REG_STRIDE:
  - THR/RBR/DLL = 0
  - IER/DLM = 1
  - FCR = 2
  - LCR = 3
  - LSR = 5
  - ADR_O = BASE_ADDR + offset*REG_STRIDE.
- Byte lanes:
  - REG_STRIDE=4: SEL_O=4'b0001, data on bit [7:0].
  - REG_STRIDE=1: SEL_O=1<<ADR_O[1:0], data on lane ADR_O[1:0].
  - Write byte is replicated on all 4 lanes of DAT_O.
- Reset values: CYC_O=STB_O=WE_O=0, ADR_O=0, DAT_O=0, SEL_O=0, tx_ready=0, rx_valid=0, rx_data=0, init_done=0, bus_err=0.
- Bus cycle:
  - CYC_O, STB_O, ADR_O, WE_O, SEL_O and DAT_O are registered and held until the first edge with ACK_I=1.
  - On that edge CYC_O and STB_O drop. Read data is captured from DAT_I on the same edge.
  - At least one idle cycle separates transactions; CYC_O is never held across transactions.
  - ACK_I is ignored while CYC_O=0.
- FSM:
  - Init states, in order, all writes:
    1. W_LCR_DLAB: LCR = 0x80
    2. W_DLL: DIVISOR[7:0]
    3. W_DLM: DIVISOR[15:8]
    4. W_LCR: LCR_VAL & 0x7F
    5. W_FCR: FCR_VAL
    6. W_IER: 0x00
  - After W_IER → IDLE. init_done goes to 1 on the W_IER ACK edge and stays 1 until reset.
  - IDLE → RD_LSR, an LSR read, unconditionally in the next cycle.
  - After the LSR ACK:
    - If LSR[0] (DR) is set and rx_valid=0 → RD_RBR.
    - Else if LSR[5] (THRE) is set and tx_valid=1 → WR_THR.
    - Else → IDLE.
    - RX has priority over TX.
  - RD_RBR: on ACK, rx_data <= DAT_I byte and rx_valid <= 1 → IDLE.
  - WR_THR: DAT_O carries tx_data. On ACK, tx_ready=1 for exactly that one cycle → IDLE.
- rx_valid clears on an edge with rx_valid & rx_ready. If DR is set while rx_valid=1, RBR is not read; the byte stays in the UART (back-pressure).
- Only one byte is written per LSR poll; THRE is re-checked before every THR write.
- Reset asserted mid-cycle: the next edge forces CYC_O=STB_O=0, drops any pending rx byte, and restarts at W_LCR_DLAB.

Optional Feature:
WB_ACK_TIMEOUT_EN:
- Defined: a counter runs while CYC_O=1. If ACK_TIMEOUT cycles elapse with no ACK, the cycle is aborted (CYC_O=STB_O=0) and bus_err is set (sticky until reset).
  - Aborted init write: the same write is retried.
  - Aborted RD_LSR, RD_RBR or WR_THR: → IDLE. No tx_ready pulse, rx_valid unchanged.
- Undefined: no counter; the initiator waits for ACK indefinitely; bus_err is tied to 0.

Test Plan:
- Reset, then a responder that ACKs 1 cycle after STB → writes in order (byte address / data):
  - 0x1250_000C/0x80
  - 0x1250_0000/0x1B
  - 0x1250_0004/0x00
  - 0x1250_000C/0x03
  - 0x1250_0008/0x07
  - 0x1250_0004/0x00
  - SEL_O=4'b0001 on every write; init_done=1 after the 6th ACK.
- LSR reads 0x60, tx_valid=1, tx_data=0x41 → write 0x1250_0000 with DAT_O[7:0]=0x41, one tx_ready pulse; with LSR=0x00 no THR write occurs.
- LSR=0x61, RBR=0x5A, tx_valid=1 → RBR read precedes the THR write; rx_data=0x5A, rx_valid=1.
- rx_valid=1, rx_ready=0, LSR=0x61 → no further RBR read. rx_ready=1 for one cycle → rx_valid=0, then the next poll reads RBR.
- RST_I asserted during a THR write with ACK withheld → next edge CYC_O=0, rx_valid=0. After release, the first cycle is the write 0x1250_000C/0x80.
- WB_ACK_TIMEOUT_EN defined, ACK_TIMEOUT=8, responder never ACKs → CYC_O drops after 8 cycles, bus_err=1, the same LCR write is retried.
